bus_dma: RTL and testbench

BUS_DMA -- requirements
Module: bus_dma

---
 rtl/bus_dma.sv | 204 ++++++++++++++++++++
 tb/tb_bus_dma.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// Single-channel line-copy DMA: a CPU-facing register window programs SRC/DST/LEN,
// and the engine moves LEN bus lines from SRC to DST, one read then one write per line.
module bus_dma #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    localparam int unsigned BUS_DATA_WIDTH = 32 * (1 << LINE_ADDR_LEN),
    localparam int unsigned LINE_BYTES = 4 << LINE_ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      slave_read_request,
    input  logic                      slave_write_request,
    input  logic [31:0]               slave_addr,
    input  logic [BUS_DATA_WIDTH-1:0] slave_write_data,
    output logic                      slave_request_finish,
    output logic [BUS_DATA_WIDTH-1:0] slave_read_data,
    output logic                      master_read_request,
    output logic                      master_write_request,
    output logic [31:0]               master_addr,
    output logic [BUS_DATA_WIDTH-1:0] master_write_data,
    input  logic                      master_request_finish,
    input  logic [BUS_DATA_WIDTH-1:0] master_read_data,
    output logic                      irq
);

    localparam logic [31:0] LINE_STEP  = 32'(LINE_BYTES);
    localparam logic [31:0] ALIGN_MASK = 32'(LINE_BYTES - 1);

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, ABORT_WAIT} state_e;

    state_e                    state_q, state_d;
    logic [31:0]               src_q, dst_q;
    logic [15:0]               len_q;
    logic [BUS_DATA_WIDTH-1:0] buf_q;
    logic                      ie_q, done_q, err_q;
    logic                      abort_wr_q;  // which request ABORT_WAIT is still holding
    logic                      finish_q;

    logic        busy, wr_evt, start_evt, abort_evt, misaligned;
    logic [2:0]  reg_sel;
    logic [31:0] wdata;
    logic        set_done, set_err, clr_status, rd_capture, line_done;
    logic        rd_active, wr_active;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{slave_addr[31:5], slave_addr[1:0],
                           slave_write_data[BUS_DATA_WIDTH-1:32]};

    assign busy    = (state_q != IDLE);
    assign reg_sel = slave_addr[4:2];
    assign wdata   = slave_write_data[31:0];
    // A write takes effect once, on the edge where finish rises.
    assign wr_evt     = slave_write_request && !finish_q;
    assign start_evt  = wr_evt && (reg_sel == 3'd3) && wdata[0] && !busy;
    assign abort_evt  = wr_evt && (reg_sel == 3'd3) && wdata[1];
    assign misaligned = ((src_q | dst_q) & ALIGN_MASK) != 32'd0;

    assign slave_request_finish = finish_q;
    assign irq = done_q & ie_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and status set/clear decisions
    always_comb begin
        state_d    = state_q;
        set_done   = 1'b0;
        set_err    = 1'b0;
        clr_status = 1'b0;
        rd_capture = 1'b0;
        line_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    if (misaligned) begin
                        set_done = 1'b1;
                        set_err  = 1'b1;
                    end else if (len_q == 16'd0) begin
                        set_done = 1'b1;
                    end else begin
                        clr_status = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            RD, WR: begin
                if (abort_evt) begin
                    // Finish arriving on the abort edge closes the transaction right away.
                    if (master_request_finish) begin
                        state_d  = IDLE;
                        set_done = 1'b1;
                        set_err  = 1'b1;
                    end else begin
                        state_d = ABORT_WAIT;
                    end
                end else if (master_request_finish) begin
                    rd_capture = (state_q == RD);
                    line_done  = (state_q == WR);
                    state_d    = (state_q == RD) ? RD_GAP : WR_GAP;
                end
            end
            RD_GAP, WR_GAP: begin
                if (abort_evt) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                    set_err  = 1'b1;
                end else if (state_q == RD_GAP) begin
                    state_d = WR;
                end else if (len_q != 16'd0) begin
                    state_d = RD;
                end else begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                end
            end
            ABORT_WAIT: begin
                if (master_request_finish) begin
                    state_d  = IDLE;
                    set_done = 1'b1;
                    set_err  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file, line buffer and handshake state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            len_q      <= 16'd0;
            buf_q      <= '0;
            ie_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            abort_wr_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            finish_q <= slave_read_request | slave_write_request;
            if (wr_evt) begin
                case (reg_sel)
                    3'd0: if (!busy) src_q <= wdata;
                    3'd1: if (!busy) dst_q <= wdata;
                    3'd2: if (!busy) len_q <= wdata[15:0];
                    3'd3: ie_q <= wdata[2];
                    3'd4: begin
                        if (wdata[1]) done_q <= 1'b0;
                        if (wdata[2]) err_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (rd_capture) buf_q <= master_read_data;
            if (line_done) begin
                src_q <= src_q + LINE_STEP;
                dst_q <= dst_q + LINE_STEP;
                len_q <= len_q - 16'd1;
            end
            // Hardware set comes last so it wins over a same-cycle W1C.
            if (clr_status) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (set_done) done_q <= 1'b1;
            if (set_err)  err_q  <= 1'b1;
            if (state_q != ABORT_WAIT) abort_wr_q <= (state_q == WR);
        end
    end

    // Master bus drive, purely from state so reset drops requests at once
    always_comb begin
        rd_active            = (state_q == RD) || (state_q == ABORT_WAIT && !abort_wr_q);
        wr_active            = (state_q == WR) || (state_q == ABORT_WAIT && abort_wr_q);
        master_read_request  = rd_active;
        master_write_request = wr_active;
        master_addr          = 32'd0;
        master_write_data    = '0;
        if (rd_active) master_addr = src_q;
        if (wr_active) begin
            master_addr       = dst_q;
            master_write_data = buf_q;
        end
    end

    // Register read mux, driven only while finish is high
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            3'd0: rdata = src_q;
            3'd1: rdata = dst_q;
            3'd2: rdata = {16'd0, len_q};
            3'd3: rdata = {29'd0, ie_q, 2'b00};
            3'd4: rdata = {29'd0, err_q, done_q, busy};
            default: rdata = 32'd0;
        endcase
        slave_read_data       = '0;
        slave_read_data[31:0] = (finish_q && slave_read_request) ? rdata : 32'd0;
    end

endmodule

// File: tb/tb_bus_dma.sv
// Directed + randomized bench for bus_dma with a latency-programmable bus responder.
module tb_bus_dma;
    localparam int unsigned LAL = 3;
    localparam int unsigned W = 32 * (1 << LAL);
    localparam logic [31:0] LB = 32'd32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         srd = 1'b0, swr = 1'b0;
    logic [31:0]  saddr = 32'd0;
    logic [W-1:0] swdata = '0;
    logic         sfin;
    logic [W-1:0] srdata;
    logic         mrd, mwr;
    logic [31:0]  maddr;
    logic [W-1:0] mwdata;
    logic         mfin = 1'b0;
    logic [W-1:0] mrdata = '0;
    logic         irq;

    int checks = 0;
    int errors = 0;

    logic [31:0]  salt;
    int           lat = 3, slow_idx = -1, slow_extra = 0, cur_lat = 3;
    logic [31:0]  rd_q[$], wr_q[$];
    logic [W-1:0] wd_q[$];
    int           gaps[$];
    int           cnt = 0, gap = 0, unstable = 0, dropped = 0, both_hi = 0;
    bit           have_prev = 0;
    logic [31:0]  hold_addr;
    logic         hold_rd;

    bus_dma #(.LINE_ADDR_LEN(LAL)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_read_request   (srd),
        .slave_write_request  (swr),
        .slave_addr           (saddr),
        .slave_write_data     (swdata),
        .slave_request_finish (sfin),
        .slave_read_data      (srdata),
        .master_read_request  (mrd),
        .master_write_request (mwr),
        .master_addr          (maddr),
        .master_write_data    (mwdata),
        .master_request_finish(mfin),
        .master_read_data     (mrdata),
        .irq                  (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pattern(input logic [31:0] a);
        logic [W-1:0] p;
        for (int i = 0; i < W / 32; i++) p[i*32 +: 32] = a ^ salt ^ (32'h0101_0101 * i);
        return p;
    endfunction

    // Memory responder: finishes each request after a programmable number of cycles.
    always @(negedge clk) begin
        if (!rst) begin
            mfin = 1'b0;
            cnt = 0;
            gap = 0;
            have_prev = 0;
        end else begin
            if (mrd && mwr) both_hi++;
            if (mfin) mfin = 1'b0;
            if (mrd || mwr) begin
                if (cnt == 0) begin
                    if (have_prev) gaps.push_back(gap);
                    hold_addr = maddr;
                    hold_rd = mrd;
                    cur_lat = lat;
                    if (mrd) begin
                        if (rd_q.size() == slow_idx) cur_lat = lat + slow_extra;
                        rd_q.push_back(maddr);
                    end
                end else if (maddr !== hold_addr || mrd !== hold_rd) begin
                    unstable++;
                end
                cnt++;
                if (cnt >= cur_lat) begin
                    mfin = 1'b1;
                    mrdata = pattern(maddr);
                    if (mwr) begin
                        wr_q.push_back(maddr);
                        wd_q.push_back(mwdata);
                    end
                    cnt = 0;
                    gap = 0;
                    have_prev = 1;
                end
            end else begin
                if (cnt != 0) dropped++;
                cnt = 0;
                gap++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input int idx, input logic [31:0] d);
        @(negedge clk);
        swr = 1'b1;
        saddr = 32'(idx * 4);
        swdata = '0;
        swdata[31:0] = d;
        @(negedge clk);
        check("wr_handshake", {31'd0, sfin}, 32'd1);
        swr = 1'b0;
    endtask

    task automatic reg_read(input int idx, output logic [31:0] d);
        @(negedge clk);
        srd = 1'b1;
        saddr = 32'(idx * 4);
        @(negedge clk);
        d = srdata[31:0];
        srd = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] v;
        reg_read(idx, v);
        check(tag, v, exp);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        s = 32'd1;
        for (int i = 0; i < 400 && s[0]; i++) reg_read(4, s);
        check("idle_wait", {31'd0, s[0]}, 32'd0);
    endtask

    task automatic clear_log();
        rd_q.delete();
        wr_q.delete();
        wd_q.delete();
        gaps.delete();
        have_prev = 0;
    endtask

    // Reference model: line k reads SRC+k*LB and writes that line to DST+k*LB.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len_w, input int l);
        int len;
        int bad;
        len = int'(len_w[15:0]);
        clear_log();
        lat = l;
        reg_write(0, src);
        reg_write(1, dst);
        reg_write(2, len_w);
        reg_write(3, 32'h1);
        wait_idle();
        check("rd_count", rd_q.size(), len);
        check("wr_count", wr_q.size(), len);
        for (int k = 0; k < len && k < rd_q.size(); k++)
            check("rd_addr", rd_q[k], src + LB * k);
        for (int k = 0; k < len && k < wr_q.size(); k++) begin
            check("wr_addr", wr_q[k], dst + LB * k);
            check("wr_data", {31'd0, wd_q[k] === pattern(src + LB * k)}, 32'd1);
        end
        bad = 0;
        foreach (gaps[i]) if (gaps[i] != 1) bad++;
        check("gap_len", bad, 0);
        check("gap_count", gaps.size(), 2 * len - 1);
        check("one_req", both_hi, 0);
        check("stable", unstable, 0);
        check("held", dropped, 0);
        expect_reg("src_end", 0, src + LB * len);
        expect_reg("dst_end", 1, dst + LB * len);
        expect_reg("len_end", 2, 32'd0);
        expect_reg("status_done", 4, 32'h2);
        reg_write(4, 32'h2);
        expect_reg("status_clr", 4, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] s, d;
        int n0;
        salt = $urandom;

        // Reset state
        #1;
        check("rst_mrd", {31'd0, mrd}, 32'd0);
        check("rst_mwr", {31'd0, mwr}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_fin", {31'd0, sfin}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        expect_reg("rst_src", 0, 32'd0);
        expect_reg("rst_len", 2, 32'd0);
        expect_reg("rst_status", 4, 32'd0);
        expect_reg("unmapped", 6, 32'd0);
        reg_write(7, 32'hFFFF_FFFF);
        @(negedge clk);
        check("fin_drop", {31'd0, sfin}, 32'd0);

        // Basic two-line copy, latency 3
        run_xfer(32'h1000, 32'h2000, 32'd2, 3);

        // Zero-length start
        clear_log();
        reg_write(3, 32'h1);
        expect_reg("len0_status", 4, 32'h2);
        check("len0_traffic", rd_q.size() + wr_q.size(), 0);
        reg_write(4, 32'h2);

        // Misaligned source
        reg_write(0, 32'h1004);
        reg_write(2, 32'd1);
        reg_write(3, 32'h1);
        expect_reg("misal_status", 4, 32'h6);
        check("misal_traffic", rd_q.size() + wr_q.size(), 0);
        check("misal_irq", {31'd0, irq}, 32'd0);
        reg_write(4, 32'h6);
        expect_reg("w1c_status", 4, 32'h0);

        // Abort during the second read, whose finish is delayed 5 extra cycles
        clear_log();
        lat = 3;
        slow_idx = 1;
        slow_extra = 5;
        reg_write(0, 32'h1000);
        reg_write(1, 32'h3000);
        reg_write(2, 32'd4);
        reg_write(3, 32'h1);
        for (int i = 0; i < 200 && rd_q.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort_reached_rd2", rd_q.size(), 2);
        reg_write(3, 32'h2);
        wait_idle();
        slow_idx = -1;
        check("abort_wr_count", wr_q.size(), 1);
        check("abort_rd_count", rd_q.size(), 2);
        check("abort_held", dropped, 0);
        expect_reg("abort_status", 4, 32'h6);
        expect_reg("abort_len", 2, 32'd3);
        expect_reg("abort_src", 0, 32'h1020);
        reg_write(4, 32'h6);

        // Randomized copies, first one wrapping past 2^32, LEN upper bits junk
        for (int t = 0; t < 3; t++) begin
            s = (t == 0) ? 32'hFFFF_FFE0 : ($urandom & ~(LB - 1));
            d = $urandom & ~(LB - 1);
            v = ($urandom << 16) | 32'($urandom_range(1, 3));
            run_xfer(s, d, v, $urandom_range(1, 4));
        end

        // Busy write protection and interrupt
        clear_log();
        lat = 4;
        reg_write(0, 32'h4000);
        reg_write(1, 32'h5000);
        reg_write(2, 32'd1);
        reg_write(3, 32'h5);
        reg_write(1, 32'h9000);
        wait_idle();
        expect_reg("busy_dst", 1, 32'h5020);
        check("busy_wr_addr", (wr_q.size() > 0) ? wr_q[0] : 32'hDEAD, 32'h5000);
        expect_reg("ctrl_ie", 3, 32'h4);
        check("irq_set", {31'd0, irq}, 32'd1);
        repeat (4) @(negedge clk);
        check("irq_hold", {31'd0, irq}, 32'd1);
        reg_write(4, 32'h2);
        @(negedge clk);
        check("irq_clr", {31'd0, irq}, 32'd0);

        // Reset during a write
        clear_log();
        lat = 6;
        reg_write(0, 32'h6000);
        reg_write(1, 32'h7000);
        reg_write(2, 32'd2);
        reg_write(3, 32'h5);
        for (int i = 0; i < 200 && !mwr; i++) begin
            @(posedge clk);
            #1;
        end
        check("saw_wr", {31'd0, mwr}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_mwr", {31'd0, mwr}, 32'd0);
        check("rst_async_mrd", {31'd0, mrd}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_log();
        expect_reg("post_src", 0, 32'd0);
        expect_reg("post_dst", 1, 32'd0);
        expect_reg("post_len", 2, 32'd0);
        expect_reg("post_ctrl", 3, 32'd0);
        expect_reg("post_status", 4, 32'd0);
        repeat (10) @(negedge clk);
        n0 = rd_q.size() + wr_q.size();
        check("post_traffic", n0, 0);
        check("post_irq", {31'd0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
